draw_square: RTL
================

# draw_square

Pixel-walker at the VGA end of the note-square path: accepts one square request (x-coordinate plus colour) and emits the per-pixel write stream to the VGA adapter. Each accepted request fills a SIZE×SIZE block at fixed row ROW_Y, one pixel per clock. It sits between the square-picking FSM, which produces square x-coordinates and colours, and the VGA adapter's x/y/colour/plot inputs.

## Interface
- SIZE, 4: square edge in pixels (1..15); a request draws SIZE*SIZE pixels.
- ROW_Y, 7'd56: y-coordinate of the square's top row.
- SCREEN_W, 160: visible width; pixels with x ≥ SCREEN_W are clipped.
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only while ready=1.
- square_x  in  8  x-coordinate of the square's top-left pixel.
- colour_in  in  3  colour of the square.
- ready  out  1  high when idle and able to accept start.
- x  out  8  pixel x to VGA adapter.
- y  out  7  pixel y to VGA adapter.
- colour  out  3  pixel colour to VGA adapter.
- plot  out  1  write-enable to VGA adapter; x/y/colour are valid when high.
- done  out  1  one-cycle pulse after the last pixel of a request.

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: ready=1. start=1 latches square_x and colour_in into internal registers, clears the column and row counters, and moves to DRAW.
- DRAW: each cycle emits one pixel in row-major order. col increments first, 0..SIZE-1. At wrap, row increments, 0..SIZE-1.
  - x = square_x_lat + col, computed 9 bits wide, output low 8 bits.
  - y = ROW_Y + row, 7 bits.
  - colour = latched colour.
- Clipping: if the 9-bit sum square_x_lat + col ≥ SCREEN_W, plot=0 for that cycle. The cycle is still consumed, so the pixel count and timing stay fixed.
- After pixel (col=SIZE-1, row=SIZE-1), move to DONE.
- DONE: done=1, plot=0, ready=0 for one cycle, then IDLE.
- start outside IDLE is ignored; there is no queueing. square_x and colour_in changes during DRAW do not affect the square in progress.
- reset in any state: next cycle is IDLE, the counters are cleared, and the request in progress is abandoned with no done pulse.

## Timing
- Reset values: ready=1, x=0, y=0, colour=0, plot=0, done=0, state IDLE.
- x, y, colour, plot and done are registered. ready is decoded from state.
- start accepted at cycle edge T → first pixel (col 0, row 0) has plot=1 in cycle T+1. Pixel k is presented in cycle T+1+k.
- Last pixel at T+SIZE*SIZE; done=1 at T+SIZE*SIZE+1; ready=1 at T+SIZE*SIZE+2.
- Throughput: one square per SIZE*SIZE+2 cycles (18 cycles at default SIZE). A start asserted in the first ready cycle is accepted.
- Outside DRAW, plot=0. x and y hold their last values; colour holds the latched value.

## Test plan
- Basic draw: square_x=0, colour_in=3'b100, start one cycle → 16 plot cycles in order (0,56)…(3,56),(0,57)…(3,59), colour=100 on each; done at cycle 17; ready at cycle 18.
- Offset square: square_x=45, colour_in=3'b000 → x sweeps 45..48 and y sweeps 56..59; plot=1 for all 16 pixels with colour=000.
- Busy rejection: start with square_x=10, then start with square_x=90 at cycle 5 → only the x=10 square is drawn; no second square follows done; ready returns at cycle 18.
- Clipping: square_x=158 → plot=1 only for col 0,1 (x=158,159) on each row; 8 writes total. col 2,3 have plot=0. done still at cycle 17.
- Reset mid-draw: reset asserted at pixel 7 → next cycle plot=0, ready=1, no done pulse. A new start with square_x=20 then draws a full 16-pixel square at x=20..23.
- Back-to-back: start held high continuously with square_x=5 → squares begin at cycles 1, 19, 37; done at cycles 17 and 35.

Source files
------------

// File: rtl/draw_square.sv
// Pixel walker for one note square: latches a request and streams SIZE x SIZE
// pixel writes (row-major, one per clock) to the VGA adapter, clipping off-screen columns.
module draw_square #(
    parameter int         SIZE     = 4,
    parameter logic [6:0] ROW_Y    = 7'd56,
    parameter int         SCREEN_W = 160
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] square_x,
    input  logic [2:0] colour_in,
    output logic       ready,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAST   = 4'(SIZE - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] sx_q, sx_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;
    logic [8:0] sum;

    // Column position kept 9 bits wide so x >= 256 never aliases back on screen.
    function automatic logic [8:0] pixel_x(input logic [7:0] base, input logic [3:0] c);
        return {1'b0, base} + {5'b0, c};
    endfunction

    function automatic logic on_screen(input logic [8:0] px);
        return px < 9'(SCREEN_W);
    endfunction

    // Counters always name the pixel currently presented on x/y.
    always_comb begin
        state_d  = state_q;
        sx_d     = sx_q;
        col_d    = col_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        sum      = 9'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DRAW;
                    sx_d     = square_x;
                    colour_d = colour_in;
                    col_d    = 4'd0;
                    row_d    = 4'd0;
                    sum      = pixel_x(square_x, 4'd0);
                    x_d      = sum[7:0];
                    y_d      = ROW_Y;
                    plot_d   = on_screen(sum);
                end
            end
            S_DRAW: begin
                if (col_q == LAST && row_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (col_q == LAST) begin
                        col_d = 4'd0;
                        row_d = row_q + 4'd1;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                    sum    = pixel_x(sx_q, col_d);
                    x_d    = sum[7:0];
                    y_d    = ROW_Y + {3'b0, row_d};
                    plot_d = on_screen(sum);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sx_q     <= 8'd0;
            col_q    <= 4'd0;
            row_q    <= 4'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sx_q     <= sx_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign done   = done_q;

endmodule
